audio_demux: RTL and testbench
==============================

AUDIO_DEMUX -- requirements
Module: audio_demux

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 6: sample-pair FIFO depth is 2**FIFO_WIDTH.
REQ-002 SHALL have parameter AUD_BIT_DEPTH, default 24: output sample width.
REQ-003 SHALL have a single clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  in  1  system clock (rising edge).
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port address  in  3  CPU register select.
REQ-007 SHALL have port read  in  1  CPU read strobe, one cycle per access.
REQ-008 SHALL have port write  in  1  CPU write strobe, one cycle per access.
REQ-009 SHALL have port datain  in  32  CPU write data.
REQ-010 SHALL have port dataout  out  32  registered CPU read data.
REQ-011 SHALL have port lrck  in  1  asynchronous I2S frame clock.
REQ-012 SHALL have port lsound_out  out  AUD_BIT_DEPTH  left sample to the I2S transmitter.
REQ-013 SHALL have port rsound_out  out  AUD_BIT_DEPTH  right sample to the I2S transmitter.
REQ-014 SHALL have port sample_valid  out  1  one-cycle pulse when lsound_out/rsound_out update.
REQ-015 SHALL have port fifo_empty  out  1  FIFO level == 0.
REQ-016 SHALL have port fifo_full  out  1  FIFO level == 2**FIFO_WIDTH.

Function
REQ-017 SHALL synchronise lrck through two flops and form a one-cycle pop request on the synced rising edge.
REQ-018 SHALL handle a write to address 0 by latching datain[31:32-AUD_BIT_DEPTH] into the left holding register.
REQ-019 SHALL handle a write to address 1 by pushing the pair {left hold, datain[31:32-AUD_BIT_DEPTH]} when fifo_full is 0; if fifo_full is 1, SHALL drop the pair and set the sticky overflow flag.
REQ-020 SHALL handle a write to address 2 as follows: bit0=1 flushes the FIFO (level 0, pointers 0); bit1=1 clears both sticky flags.
REQ-021 SHALL handle a write to address 4 by setting run = datain[0].
REQ-022 SHALL, on a pop request with run=1 and fifo_empty=0, present the head pair on lsound_out/rsound_out one cycle later, pulse sample_valid, and decrement the level.
REQ-023 SHALL, on a pop request with run=1 and fifo_empty=1, drive both outputs to 0, pulse sample_valid, and set the sticky underrun flag.
REQ-024 SHALL, on a pop request with run=0, leave the FIFO untouched, drive both outputs to 0, and assert no sample_valid.
REQ-025 SHALL evaluate full/empty using pre-cycle values: a push and a pop in the same cycle on a non-empty, non-full FIFO both complete and leave the level unchanged; a push on a full FIFO is dropped even if a pop occurs in the same cycle; a pop on an empty FIFO underruns even if a push occurs in the same cycle.
REQ-026 SHALL give flush priority over a push or pop in the same cycle.
REQ-027 SHALL return read data one cycle after read for each address:
- address 2: {14'b0, underrun[17], overflow[16], 9'b0, level[FIFO_WIDTH:0]} (FIFO_WIDTH <= 15);
- address 3: underrun counter;
- address 4: {31'b0, run};
- others: 0.
REQ-028 SHALL wrap the FIFO pointers modulo 2**FIFO_WIDTH, with level FIFO_WIDTH+1 bits wide.

Reset
REQ-029 SHALL, while reset=1, clear pointers, level, run, stickies, holding register, counter, dataout, outputs and sample_valid to 0, with fifo_empty=1 and fifo_full=0.
REQ-030 SHALL, on reset mid-operation, discard FIFO contents, and SHALL not generate a pop from a synced lrck edge during the first cycle after reset release.

Configuration
REQ-031 SHALL, with macro AUDIO_DEMUX_UNDERRUN_CNT_EN defined, implement a 16-bit saturating counter that increments on each underrun pop, is cleared by a write to address 2 with bit1=1, and is readable at address 3.
REQ-032 SHALL, without AUDIO_DEMUX_UNDERRUN_CNT_EN, implement no counter, with address 3 reading 0.

Verification
REQ-033 SHALL cover: run=1; write addr0 0x123456_00, addr1 0xABCDEF_00; lrck rise -> after sync, lsound_out=0x123456, rsound_out=0xABCDEF, one sample_valid pulse, level 1->0.
REQ-034 SHALL cover: push 64 pairs (FIFO_WIDTH=6) -> fifo_full=1; 65th addr1 write -> dropped, addr2 read bit16=1, level=64.
REQ-035 SHALL cover: empty FIFO, run=1, three lrck rises -> outputs 0, underrun bit17=1, addr3 reads 3 (macro on) or 0 (macro off).
REQ-036 SHALL cover: level 5, addr1 push coinciding with pop request -> level stays 5 and popped data is the oldest pair.
REQ-037 SHALL cover: level 10, assert reset for 3 cycles mid-stream -> all outputs 0, fifo_empty=1, addr2 reads 0 afterwards.

Source files
------------

// File: rtl/audio_demux.sv
// CPU-fed stereo sample FIFO drained by the rising edge of an asynchronous I2S frame clock.
// Optional build macro AUDIO_DEMUX_UNDERRUN_CNT_EN adds a 16-bit saturating underrun counter at address 3.
module audio_demux #(
  parameter int FIFO_WIDTH    = 6,
  parameter int AUD_BIT_DEPTH = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               address,
  input  logic                     read,
  input  logic                     write,
  input  logic [31:0]              datain,
  output logic [31:0]              dataout,
  input  logic                     lrck,
  output logic [AUD_BIT_DEPTH-1:0] lsound_out,
  output logic [AUD_BIT_DEPTH-1:0] rsound_out,
  output logic                     sample_valid,
  output logic                     fifo_empty,
  output logic                     fifo_full
);
  localparam int DEPTH  = 1 << FIFO_WIDTH;
  localparam int PAIR_W = 2 * AUD_BIT_DEPTH;

  logic [PAIR_W-1:0]        mem [DEPTH];
  logic [FIFO_WIDTH-1:0]    wr_ptr, rd_ptr;
  logic [FIFO_WIDTH:0]      level;
  logic [AUD_BIT_DEPTH-1:0] left_hold, sample_in;
  logic                     run, overflow, underrun;
  logic                     lrck_s1, lrck_s2, lrck_d, armed;
  logic                     pop_req, wr_left, wr_push, wr_ctrl, wr_run;
  logic                     flush, clr_sticky, do_push, do_pop, do_under, drop_push;
  logic [31:0]              status, cnt_word, rd_data;
  logic                     unused_datain;

  // CPU access: read/write are one-cycle strobes with no ready; every access completes
  // in the cycle it is strobed, and read data lands on dataout one cycle after read.
  assign wr_left    = write && (address == 3'd0);
  assign wr_push    = write && (address == 3'd1);
  assign wr_ctrl    = write && (address == 3'd2);
  assign wr_run     = write && (address == 3'd4);
  assign sample_in  = datain[31 -: AUD_BIT_DEPTH];
  assign flush      = wr_ctrl & datain[0];
  assign clr_sticky = wr_ctrl & datain[1];
  assign unused_datain = ^datain;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (FIFO_WIDTH+1)'(DEPTH));

  // armed stays low for the first cycle after reset so a stale sync edge cannot pop.
  assign pop_req   = lrck_s2 & ~lrck_d & armed;
  assign do_push   = wr_push & ~fifo_full & ~flush;
  assign drop_push = wr_push & fifo_full;
  assign do_pop    = pop_req & run & ~fifo_empty & ~flush;
  assign do_under  = pop_req & run & fifo_empty & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lrck_s1 <= 1'b0;
      lrck_s2 <= 1'b0;
      lrck_d  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      lrck_s1 <= lrck;
      lrck_s2 <= lrck_s1;
      lrck_d  <= lrck_s2;
      armed   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {left_hold, sample_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      left_hold    <= '0;
      run          <= 1'b0;
      overflow     <= 1'b0;
      underrun     <= 1'b0;
      lsound_out   <= '0;
      rsound_out   <= '0;
      sample_valid <= 1'b0;
      dataout      <= '0;
    end else begin
      sample_valid <= pop_req & run & ~flush;
      if (wr_left) left_hold <= sample_in;
      if (wr_run) run <= datain[0];
      if (read) dataout <= rd_data;
      // A new event in the same cycle as a clear wins so it is never lost.
      if (clr_sticky) begin
        overflow <= 1'b0;
        underrun <= 1'b0;
      end
      if (drop_push) overflow <= 1'b1;
      if (do_under) underrun <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        if (do_push && !do_pop) level <= level + 1'b1;
        else if (!do_push && do_pop) level <= level - 1'b1;
      end
      if (pop_req && !flush) begin
        if (do_pop) begin
          {lsound_out, rsound_out} <= mem[rd_ptr];
        end else begin
          lsound_out <= '0;
          rsound_out <= '0;
        end
      end
    end
  end

`ifdef AUDIO_DEMUX_UNDERRUN_CNT_EN
  logic [15:0] under_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      under_cnt <= '0;
    end else if (do_under) begin
      if (under_cnt != 16'hFFFF) under_cnt <= under_cnt + 1'b1;
    end else if (clr_sticky) begin
      under_cnt <= '0;
    end
  end

  assign cnt_word = {16'b0, under_cnt};
`else
  assign cnt_word = '0;
`endif

  always_comb begin
    status                = '0;
    status[FIFO_WIDTH:0]  = level;
    status[16]            = overflow;
    status[17]            = underrun;
  end

  always_comb begin
    rd_data = '0;
    case (address)
      3'd2:    rd_data = status;
      3'd3:    rd_data = cnt_word;
      3'd4:    rd_data = {31'b0, run};
      default: rd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_audio_demux.sv
// Self-checking bench for audio_demux: register vector table, directed corner sequences,
// and a randomized phase scored against a queue-based model of the sample FIFO.
module tb_audio_demux;
  localparam int FW    = 6;
  localparam int DEPTH = 64;
  localparam int AW    = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    address = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   datain = '0;
  logic [31:0]   dataout;
  logic          lrck = 1'b0;
  logic [AW-1:0] lsound_out, rsound_out;
  logic          sample_valid, fifo_empty, fifo_full;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the FIFO contents as a plain queue plus the visible registers.
  logic [2*AW-1:0] exp_q[$];
  logic [AW-1:0]   m_left = '0;
  logic            m_run = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
  int              m_cnt = 0;

  typedef struct {
    logic        do_wr;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[15];

  audio_demux #(.FIFO_WIDTH(FW), .AUD_BIT_DEPTH(AW)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .datain(datain), .dataout(dataout), .lrck(lrck),
    .lsound_out(lsound_out), .rsound_out(rsound_out), .sample_valid(sample_valid),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[FW:0] = 7'(exp_q.size());
    s[16] = m_ovf;
    s[17] = m_unf;
    return s;
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef AUDIO_DEMUX_UNDERRUN_CNT_EN
    return 32'(m_cnt);
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_left = '0;
    m_run = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_push(input logic [31:0] d, input logic was_full);
    if (was_full) m_ovf = 1'b1;
    else exp_q.push_back({m_left, d[31:8]});
  endtask

  task automatic model_pop(output logic exp_v, output logic [2*AW-1:0] exp_d);
    exp_v = m_run;
    exp_d = '0;
    if (m_run) begin
      if (exp_q.size() == 0) begin
        m_unf = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        exp_d = exp_q.pop_front();
      end
    end
  endtask

  // Drivers: every task starts and ends just after a falling edge.
  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    address = a;
    datain  = d;
    write   = 1'b1;
    case (a)
      3'd0: m_left = d[31:8];
      3'd1: model_push(d, exp_q.size() == DEPTH);
      3'd2: begin
        if (d[0]) exp_q.delete();
        if (d[1]) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
          m_cnt = 0;
        end
      end
      3'd4: m_run = d[0];
      default: ;
    endcase
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [31:0] v);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    read = 1'b0;
    v = dataout;
  endtask

  task automatic check_status(input string name);
    logic [31:0] v;
    cpu_read(3'd2, v);
    check(name, v, exp_status());
  endtask

  task automatic check_flags();
    check("fifo_empty", fifo_empty, exp_q.size() == 0);
    check("fifo_full", fifo_full, exp_q.size() == DEPTH);
  endtask

  // lrck rise; the pop request is live two cycles later, optionally alongside an addr1 push.
  task automatic lrck_pop(input logic with_push, input logic [31:0] d);
    logic            exp_v, pre_full;
    logic [2*AW-1:0] exp_d;
    lrck = 1'b1;
    repeat (2) @(negedge clk);
    if (with_push) begin
      address = 3'd1;
      datain  = d;
      write   = 1'b1;
    end
    pre_full = (exp_q.size() == DEPTH);
    model_pop(exp_v, exp_d);
    if (with_push) model_push(d, pre_full);
    @(negedge clk);
    write = 1'b0;
    lrck  = 1'b0;
    check("sample_valid", sample_valid, exp_v);
    check("lsound_out", lsound_out, exp_d[47:24]);
    check("rsound_out", rsound_out, exp_d[23:0]);
    @(negedge clk);
    check("valid_pulse_end", sample_valid, 64'd0);
    @(negedge clk);
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("rst_lsound", lsound_out, 64'd0);
      check("rst_rsound", rsound_out, 64'd0);
      check("rst_valid", sample_valid, 64'd0);
      check("rst_dataout", dataout, 64'd0);
      check("rst_empty", fifo_empty, 64'd1);
      check("rst_full", fifo_full, 64'd0);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;

    vecs[0]  = '{1'b1, 3'd4, 32'h0000_0001, 3'd4, 32'h1};
    vecs[1]  = '{1'b1, 3'd4, 32'h0000_0000, 3'd4, 32'h0};
    vecs[2]  = '{1'b1, 3'd4, 32'hFFFF_FFFE, 3'd4, 32'h0};
    vecs[3]  = '{1'b1, 3'd4, 32'h0000_0003, 3'd4, 32'h1};
    vecs[4]  = '{1'b0, 3'd0, 32'h0,         3'd0, 32'h0};
    vecs[5]  = '{1'b0, 3'd0, 32'h0,         3'd5, 32'h0};
    vecs[6]  = '{1'b0, 3'd0, 32'h0,         3'd6, 32'h0};
    vecs[7]  = '{1'b0, 3'd0, 32'h0,         3'd7, 32'h0};
    vecs[8]  = '{1'b0, 3'd0, 32'h0,         3'd1, 32'h0};
    vecs[9]  = '{1'b1, 3'd0, 32'h1234_5600, 3'd2, 32'h0};
    vecs[10] = '{1'b1, 3'd1, 32'hABCD_EF00, 3'd2, 32'h1};
    vecs[11] = '{1'b1, 3'd1, 32'h1111_1100, 3'd2, 32'h2};
    vecs[12] = '{1'b1, 3'd2, 32'h0000_0001, 3'd2, 32'h0};
    vecs[13] = '{1'b0, 3'd0, 32'h0,         3'd3, 32'h0};
    vecs[14] = '{1'b1, 3'd4, 32'h0000_0000, 3'd4, 32'h0};

    // Reset state
    apply_reset(3);

    // Register vector table
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].do_wr) cpu_write(vecs[i].waddr, vecs[i].wdata);
      cpu_read(vecs[i].raddr, v);
      check($sformatf("reg_vec%0d", i), v, vecs[i].exp);
    end

    // Single pair through the FIFO
    cpu_write(3'd4, 32'h1);
    cpu_write(3'd0, 32'h1234_5600);
    cpu_write(3'd1, 32'hABCD_EF00);
    cpu_read(3'd2, v);
    check("basic_level1", v, 32'h1);
    lrck_pop(1'b0, 32'h0);
    check("basic_left", lsound_out, 24'h123456);
    check("basic_right", rsound_out, 24'hABCDEF);
    cpu_read(3'd2, v);
    check("basic_level0", v, 32'h0);

    // Fill to full, then one dropped push
    cpu_write(3'd4, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("full_at_63", fifo_full, 64'd0);
      cpu_write(3'd0, $urandom);
      cpu_write(3'd1, $urandom);
    end
    check("full_at_64", fifo_full, 64'd1);
    cpu_write(3'd1, 32'hDEAD_BE00);
    cpu_read(3'd2, v);
    check("overflow_status", v, 32'h0001_0040);
    cpu_write(3'd4, 32'h1);
    for (int i = 0; i < DEPTH; i++) lrck_pop(1'b0, 32'h0);
    check_flags();
    check_status("drained_status");
    cpu_write(3'd2, 32'h2);
    check_status("cleared_status");

    // Underrun on an empty FIFO
    for (int i = 0; i < 3; i++) lrck_pop(1'b0, 32'h0);
    cpu_read(3'd2, v);
    check("underrun_status", v, 32'h0002_0000);
    cpu_read(3'd3, v);
    check("underrun_cnt", v, exp_cnt());
    cpu_write(3'd2, 32'h2);
    cpu_read(3'd3, v);
    check("underrun_cnt_clr", v, 32'h0);

    // Pop with run=0 leaves the FIFO alone
    cpu_write(3'd0, 32'h0102_0300);
    cpu_write(3'd1, 32'h0405_0600);
    cpu_write(3'd4, 32'h0);
    lrck_pop(1'b0, 32'h0);
    check_status("norun_status");
    cpu_write(3'd2, 32'h3);

    // Push coinciding with pop at level 5
    cpu_write(3'd4, 32'h1);
    for (int i = 0; i < 5; i++) begin
      cpu_write(3'd0, {24'h100000 + 24'(i), 8'h00});
      cpu_write(3'd1, {24'h200000 + 24'(i), 8'h00});
    end
    lrck_pop(1'b1, 32'h3000_0500);
    check("coinc_left", lsound_out, 24'h100000);
    check("coinc_right", rsound_out, 24'h200000);
    cpu_read(3'd2, v);
    check("coinc_level", v, 32'h5);
    for (int i = 0; i < 5; i++) lrck_pop(1'b0, 32'h0);
    check_flags();

    // Randomized traffic against the model
    cpu_write(3'd4, 32'h1);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          cpu_write(3'd0, $urandom);
          cpu_write(3'd1, $urandom);
        end
        3, 4, 5: lrck_pop($urandom_range(0, 3) == 0, $urandom);
        6: check_status("rand_status");
        7: cpu_write(3'd4, {31'b0, $urandom_range(0, 4) != 0});
        8: begin
          cpu_read(3'd3, v);
          check("rand_cnt", v, exp_cnt());
        end
        default: cpu_write(3'd2, ($urandom_range(0, 5) == 0) ? 32'h3 : 32'h0);
      endcase
      check_flags();
    end

    // Reset in the middle of a stream at level 10
    cpu_write(3'd2, 32'h3);
    cpu_write(3'd4, 32'h1);
    for (int i = 0; i < 10; i++) begin
      cpu_write(3'd0, $urandom | 32'h8000_0000);
      cpu_write(3'd1, $urandom | 32'h8000_0000);
    end
    lrck_pop(1'b0, 32'h0);
    cpu_write(3'd0, 32'h7777_7700);
    cpu_write(3'd1, 32'h8888_8800);
    cpu_read(3'd2, v);
    check("pre_reset_level", v, 32'd10);
    apply_reset(3);
    cpu_read(3'd2, v);
    check("post_reset_status", v, 32'h0);
    cpu_read(3'd4, v);
    check("post_reset_run", v, 32'h0);
    check_flags();
    cpu_write(3'd4, 32'h1);
    cpu_write(3'd0, 32'h5555_5500);
    cpu_write(3'd1, 32'h6666_6600);
    lrck_pop(1'b0, 32'h0);
    check_flags();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
